booth_mul_arbiter: RTL

- Shares one sequential 8-bit signed multiplier (load/ready style, 16-bit product) between NUM_REQ requesters.
- Performs round-robin arbitration and captures the winner's operands.
- Sequences the multiplier through load and compute, with a watchdog timeout.
- Returns the tagged product on a valid/ready response channel. Sits between requesting engines and the shared multiplier instance.

---
 rtl/booth_mul_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/booth_mul_arbiter.sv
// Purpose : round-robin front end that shares one sequential 8x8 signed multiplier between NUM_REQ requesters.
// Latency : grant at G, mul_load at G+1, response valid the cycle after the first qualifying mul_rdy (or after TIMEOUT busy cycles).
// Backpr. : one job in flight; requests are accepted only in IDLE, and the response is held stable until rsp_ready.
//
// Ports:
//   clk, reset (async, active low)
//   req_valid/req_a/req_b/req_ready : per-requester request channel, operands packed 8 bits per lane
//   mul_load/mul_a/mul_b/mul_rdy/mul_p : shared multiplier interface
//   rsp_valid/rsp_ready/rsp_id/rsp_p/rsp_err : tagged response channel
//   busy : high whenever a job is in progress
module booth_mul_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2,
   parameter int TIMEOUT = 40
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [NUM_REQ*8-1:0] req_a,
   input  logic [NUM_REQ*8-1:0] req_b,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic                 mul_load,
   output logic [7:0]           mul_a,
   output logic [7:0]           mul_b,
   input  logic                 mul_rdy,
   input  logic [15:0]          mul_p,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [ID_W-1:0]      rsp_id,
   output logic [15:0]          rsp_p,
   output logic                 rsp_err,
   output logic                 busy
);

   localparam int CNT_W  = $clog2(TIMEOUT + 1);
   localparam int SCAN_W = ID_W + 1;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_BUSY, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]   id_q, id_d;
   logic [7:0]        mul_a_q, mul_a_d;
   logic [7:0]        mul_b_q, mul_b_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [15:0]       rsp_p_q, rsp_p_d;
   logic              rsp_err_q, rsp_err_d;

   logic              gnt_found;
   logic [ID_W-1:0]   gnt_idx;
   logic [SCAN_W-1:0] scan;

   // Rotating priority search: start at rr_ptr and wrap modulo NUM_REQ.
   // The extra scan bit keeps the wrap correct for non-power-of-two NUM_REQ.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      scan      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan = {1'b0, rr_ptr_q} + SCAN_W'(k);
         if (scan >= SCAN_W'(NUM_REQ)) begin
            scan = scan - SCAN_W'(NUM_REQ);
         end
         if (!gnt_found && req_valid[scan[ID_W-1:0]]) begin
            gnt_found = 1'b1;
            gnt_idx   = scan[ID_W-1:0];
         end
      end
   end

   // Gated by reset so every output is low while reset is held, even with requests pending.
   always_comb begin
      req_ready = '0;
      if (reset && (state_q == S_IDLE) && gnt_found) begin
         req_ready[gnt_idx] = 1'b1;
      end
   end

   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      id_d      = id_q;
      mul_a_d   = mul_a_q;
      mul_b_d   = mul_b_q;
      cnt_d     = cnt_q;
      rsp_p_d   = rsp_p_q;
      rsp_err_d = rsp_err_q;
      case (state_q)
         S_IDLE: begin
            if (gnt_found) begin
               mul_a_d = req_a[int'(gnt_idx)*8 +: 8];
               mul_b_d = req_b[int'(gnt_idx)*8 +: 8];
               id_d    = gnt_idx;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            cnt_d   = '0;
            state_d = S_BUSY;
         end
         S_BUSY: begin
            cnt_d = cnt_q + 1'b1;
            // cnt_q == 0 is the first busy cycle, where mul_rdy still reflects the previous job.
            if ((cnt_q != '0) && mul_rdy) begin
               rsp_p_d   = mul_p;
               rsp_err_d = 1'b0;
               state_d   = S_DONE;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               rsp_p_d   = '0;
               rsp_err_d = 1'b1;
               state_d   = S_DONE;
            end
         end
         S_DONE: begin
            if (rsp_ready) begin
               // The requester just served drops to lowest priority.
               if (id_q == ID_W'(NUM_REQ - 1)) begin
                  rr_ptr_d = '0;
               end else begin
                  rr_ptr_d = id_q + 1'b1;
               end
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         rr_ptr_q  <= '0;
         id_q      <= '0;
         mul_a_q   <= '0;
         mul_b_q   <= '0;
         cnt_q     <= '0;
         rsp_p_q   <= '0;
         rsp_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         id_q      <= id_d;
         mul_a_q   <= mul_a_d;
         mul_b_q   <= mul_b_d;
         cnt_q     <= cnt_d;
         rsp_p_q   <= rsp_p_d;
         rsp_err_q <= rsp_err_d;
      end
   end

   assign mul_load  = (state_q == S_LOAD);
   assign mul_a     = mul_a_q;
   assign mul_b     = mul_b_q;
   assign rsp_valid = (state_q == S_DONE);
   assign rsp_id    = id_q;
   assign rsp_p     = rsp_p_q;
   assign rsp_err   = rsp_err_q;
   assign busy      = (state_q != S_IDLE);

endmodule
